// File: rtl/sc_reg_host.sv
// sc_reg_host: SPI mode-0 initiator serialising single flash status/control register requests.
// Define SC_REG_HOST_AUTO_WREN_EN to precede every legal 71h write with its own 06h frame.
module sc_reg_host #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [7:0]  req_addr,
  input  logic [1:0]  req_len,
  input  logic [23:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [23:0] rsp_rdata,
  output logic        busy,
  output logic        spi_sck,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso
);
`ifdef SC_REG_HOST_AUTO_WREN_EN
  localparam logic AUTO_WREN = 1'b1;
`else
  localparam logic AUTO_WREN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, CS_GAP} state_t;
  state_t r_state, w_next;
  logic [7:0] r_cnt, r_addr;
  logic r_sck, r_pre, r_rsp_valid, r_rsp_err;
  logic [5:0] r_bit, r_last;
  logic [63:0] r_tx;
  logic [23:0] r_rx, r_wdata, r_rdata, w_rdata;
  logic [2:0] r_op;
  logic [1:0] r_len;
  logic w_accept, w_illegal, w_tick, w_rise, w_fall, w_chain, w_load, w_auto, w_done;
  // Frame is left-aligned with zero fill, so shifting past the last bit leaves mosi low.
  function automatic logic [63:0] frame(input logic [2:0] op, input logic [7:0] addr,
                                        input logic [1:0] len, input logic [23:0] wd);
    logic [7:0] b1, b2;
    b1 = len > 2'd1 ? wd[15:8] : 8'h0;
    b2 = len == 2'd3 ? wd[23:16] : 8'h0;
    return op == 3'd0 ? {8'h06, 56'h0} : op == 3'd1 ? {8'h04, 56'h0} :
           op == 3'd2 ? {8'h05, 56'h0} : op == 3'd3 ? {8'h65, 24'h0, addr, 24'h0} :
           {8'h71, 24'h0, addr, wd[7:0], b1, b2};
  endfunction
  function automatic logic [5:0] last_bit(input logic [2:0] op, input logic [1:0] len);
    return op < 3'd2 ? 6'd7 : op == 3'd2 ? 6'd15 : 6'd39 + {1'b0, len, 3'b000};
  endfunction
  assign w_accept = req_valid && r_state == IDLE;
  assign w_illegal = req_op > 3'd4 || (req_op > 3'd2 && req_len == 2'd0);
  assign w_tick = r_cnt == 8'd0;
  assign w_rise = r_state == SHIFT && w_tick && !r_sck;
  assign w_fall = r_state == SHIFT && w_tick && r_sck;
  assign w_chain = r_state == CS_GAP && w_tick && r_pre;
  assign w_load = (w_accept && !w_illegal) || w_chain;
  assign w_auto = AUTO_WREN && req_op == 3'd4;
  assign w_done = r_state == CS_HOLD && w_tick && !r_pre;
  // Only the last 8*len received bits are data; byte0 arrived first so it sits highest.
  assign w_rdata = r_op == 3'd2 || (r_op == 3'd3 && r_len == 2'd1) ? {16'h0, r_rx[7:0]} :
                   r_op != 3'd3 ? 24'h0 :
                   r_len == 2'd2 ? {8'h0, r_rx[7:0], r_rx[15:8]} : {r_rx[7:0], r_rx[15:8], r_rx[23:16]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = w_accept && !w_illegal ? CS_SETUP : IDLE;
      CS_SETUP: w_next = w_tick ? SHIFT : CS_SETUP;
      SHIFT:    w_next = w_fall && r_bit == r_last ? CS_HOLD : SHIFT;
      CS_HOLD:  w_next = w_tick ? CS_GAP : CS_HOLD;
      CS_GAP:   w_next = w_tick ? (r_pre ? CS_SETUP : IDLE) : CS_GAP;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
      r_pre <= 1'b0;
      r_bit <= '0;
      r_last <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_op <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_cnt <= (w_next != r_state || w_tick) ? (w_next == CS_GAP ? 8'(CS_IDLE - 1) : 8'(CLK_DIV - 1))
                                             : r_cnt - 8'd1;
      r_rsp_valid <= w_done || (w_accept && w_illegal);
      r_rsp_err <= w_accept && w_illegal;
      if (w_done || (w_accept && w_illegal)) r_rdata <= w_accept ? 24'h0 : w_rdata;
      if (w_accept) begin
        r_op <= req_op;
        r_addr <= req_addr;
        r_len <= req_len;
        r_wdata <= req_wdata;
      end
      if (w_load) begin
        r_tx <= !w_accept ? frame(r_op, r_addr, r_len, r_wdata) :
                w_auto ? {8'h06, 56'h0} : frame(req_op, req_addr, req_len, req_wdata);
        r_last <= !w_accept ? last_bit(r_op, r_len) : w_auto ? 6'd7 : last_bit(req_op, req_len);
        r_bit <= '0;
        r_sck <= 1'b0;
        r_pre <= w_accept && w_auto;
      end else begin
        if (w_rise || w_fall) r_sck <= !r_sck;
        if (w_rise) r_rx <= {r_rx[22:0], spi_miso};
        if (w_fall) begin
          r_tx <= {r_tx[62:0], 1'b0};
          r_bit <= r_bit + 6'd1;
        end
      end
    end
  end
  assign req_ready = r_state == IDLE;
  assign busy = r_state != IDLE;
  assign spi_sck = r_sck;
  assign spi_cs_n = r_state == IDLE || r_state == CS_GAP;
  assign spi_mosi = r_tx[63];
  assign rsp_valid = r_rsp_valid;
  assign rsp_err = r_rsp_err;
  assign rsp_rdata = r_rdata;
endmodule

// File: tb/tb_sc_reg_host.sv
// tb_sc_reg_host: directed requests against a timing/frame model and a simple flash responder.
module tb_sc_reg_host;
  localparam int CD = 2;
  localparam int CI = 4;
  logic clk = 0, rst_n = 0, req_valid = 0, spi_miso = 0;
  logic [2:0] req_op = 0;
  logic [7:0] req_addr = 0;
  logic [1:0] req_len = 0;
  logic [23:0] req_wdata = 0;
  logic req_ready, rsp_valid, rsp_err, busy, spi_sck, spi_cs_n, spi_mosi;
  logic [23:0] rsp_rdata;
  int checks = 0, errors = 0, cyc = 0;
  int acc = -1000000, lat = 1, end1 = 0, st2 = 0, rdy_k = 0;
  logic exp_err = 0;
  logic [23:0] exp_rdata = 0;
  bit chk_en = 0;
  int rsp_cnt = 0, last_rsp_cyc = 0;
  logic [23:0] last_rdata = 0;
  logic [63:0] pat = 0, fcap = 0;
  logic [63:0] fr_bits[32];
  int fr_n[32];
  int nfr = 0, fcnt = 0, fbit = 0;
  logic prev_cs = 1, prev_sck = 0;

  sc_reg_host #(.CLK_DIV(CD), .CS_IDLE(CI)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Flash responder: records MOSI on SCK rise, drives MISO after SCK fall / CS fall.
  always @(negedge clk) begin
    if (prev_cs && !spi_cs_n) begin
      fbit <= 0;
      fcnt <= 0;
      fcap <= 0;
      spi_miso <= pat[63];
    end else if (!spi_cs_n && prev_sck && !spi_sck) begin
      fbit <= fbit + 1;
      spi_miso <= (fbit < 63) ? pat[62-fbit] : 1'b0;
    end
    if (!spi_cs_n && !prev_sck && spi_sck) begin
      fcap <= {fcap[62:0], spi_mosi};
      fcnt <= fcnt + 1;
    end
    if (!prev_cs && spi_cs_n && nfr < 32) begin
      fr_bits[nfr] <= fcap;
      fr_n[nfr] <= fcnt;
      nfr <= nfr + 1;
    end
    prev_cs <= spi_cs_n;
    prev_sck <= spi_sck;
  end

  // Per-cycle compare against the window model (k = cycles since the acceptance edge).
  always @(negedge clk) begin
    int k;
    logic cs_lo, rv, rdy;
    k = cyc - acc;
    rv = k == lat - 1;
    cs_lo = (k >= 0 && k < end1) || (k >= st2 && k < lat - 1);
    rdy = !(k >= 0 && k < rdy_k);
    if (rsp_valid === 1'b1) begin
      rsp_cnt <= rsp_cnt + 1;
      last_rsp_cyc <= cyc;
      last_rdata <= rsp_rdata;
    end
    if (chk_en) begin
      chk("rsp_valid", rsp_valid, rv);
      chk("spi_cs_n", spi_cs_n, !cs_lo);
      chk("req_ready", req_ready, rdy);
      chk("busy", busy, !rdy);
      if (!cs_lo) chk("sck_idle", spi_sck, 0);
      if (rv) begin
        chk("rsp_err", rsp_err, exp_err);
        if (!exp_err) chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
    end
  end

  task automatic run(input string nm, input logic [2:0] op, input logic [7:0] addr, input logic [1:0] len,
                     input logic [23:0] wd, input logic [23:0] rd, input int abort_at);
    logic [7:0] q[$];
    logic [63:0] fexp;
    int h, nrd, nbits, nframes, fbase, rbase;
    bit ill, auto;
    ill = op > 4 || (op >= 3 && len == 0);
    auto = 0;
`ifdef SC_REG_HOST_AUTO_WREN_EN
    auto = op == 4 && !ill;
`endif
    h = op >= 3 ? 5 : 1;
    nrd = ill ? 0 : op == 2 ? 1 : op == 3 ? int'(len) : 0;
    if (!ill) begin
      q.push_back(op == 0 ? 8'h06 : op == 1 ? 8'h04 : op == 2 ? 8'h05 : op == 3 ? 8'h65 : 8'h71);
      if (op >= 3) begin
        q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(addr);
      end
      for (int i = 0; i < nrd; i++) q.push_back(8'h00);
      if (op == 4) for (int i = 0; i < int'(len); i++) q.push_back(wd[8*i +: 8]);
    end
    fexp = 0;
    foreach (q[i]) fexp = (fexp << 8) | 64'(q[i]);
    nbits = 8 * q.size();
    nframes = ill ? 0 : auto ? 2 : 1;
    @(negedge clk);
    #1;
    pat = 0;
    exp_rdata = 0;
    for (int i = 0; i < nrd; i++) begin
      pat[63-8*(h+i) -: 8] = rd[8*i +: 8];
      exp_rdata[8*i +: 8] = rd[8*i +: 8];
    end
    exp_err = ill;
    if (ill) begin
      lat = 1; end1 = 0; st2 = 0; rdy_k = 0;
    end else if (auto) begin
      end1 = 2*CD + 2*CD*8;
      st2 = end1 + CI;
      lat = st2 + 2*CD + 2*CD*nbits + 1;
      rdy_k = lat - 1 + CI;
    end else begin
      lat = 2*CD + 2*CD*nbits + 1;
      end1 = lat - 1; st2 = lat - 1;
      rdy_k = lat - 1 + CI;
    end
    fbase = nfr;
    rbase = rsp_cnt;
    req_op = op; req_addr = addr; req_len = len; req_wdata = wd;
    req_valid = 1;
    acc = cyc + 1;
    @(posedge clk);
    #1 req_valid = 0;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      #2;
      acc = -1000000;
      rst_n = 0;
      #1;
      chk({nm, "_rst_cs_n"}, spi_cs_n, 1);
      chk({nm, "_rst_sck"}, spi_sck, 0);
      chk({nm, "_rst_mosi"}, spi_mosi, 0);
      chk({nm, "_rst_ready"}, req_ready, 1);
      chk({nm, "_rst_rsp"}, rsp_valid, 0);
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (20) @(negedge clk);
      chk({nm, "_no_rsp"}, rsp_cnt - rbase, 0);
      return;
    end
    repeat (rdy_k + 4) @(negedge clk);
    chk({nm, "_frames"}, nfr - fbase, nframes);
    chk({nm, "_rsp_count"}, rsp_cnt - rbase, 1);
    if (nframes > 0) begin
      chk({nm, "_bits"}, fr_n[nfr-1], nbits);
      chk({nm, "_mosi"}, fr_bits[nfr-1], fexp);
    end
    if (nframes == 2) begin
      chk({nm, "_wren_bits"}, fr_n[nfr-2], 8);
      chk({nm, "_wren_mosi"}, fr_bits[nfr-2], 64'h06);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_cs_n", spi_cs_n, 1);
    chk("reset_sck", spi_sck, 0);
    chk("reset_mosi", spi_mosi, 0);
    chk("reset_ready", req_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_rdata", rsp_rdata, 0);
    rst_n = 1;
    chk_en = 1;
    run("rdsr", 3'd2, 8'h00, 2'd0, 24'h0, 24'h0000A5, 0);
    chk("rdsr_latency", last_rsp_cyc - acc + 1, 69);
    chk("rdsr_rdata_lit", last_rdata, 24'h0000A5);
    chk("rdsr_sck_rises", fr_n[nfr-1], 16);
    chk("rdsr_mosi_lit", fr_bits[nfr-1], 64'h0500);
    run("rdreg2", 3'd3, 8'h01, 2'd2, 24'h0, 24'h00813C, 0);
    chk("rdreg2_rdata_lit", last_rdata, 24'h00813C);
    chk("rdreg2_mosi_lit", fr_bits[nfr-1], 64'h0065000000010000);
    run("rdreg3", 3'd3, 8'h7F, 2'd3, 24'h0, 24'h5AC396, 0);
    chk("rdreg3_latency", last_rsp_cyc - acc + 1, 261);
    run("rdreg1", 3'd3, 8'h10, 2'd1, 24'h0, 24'hFFFFE1, 0);
    chk("rdreg1_rdata_lit", last_rdata, 24'h0000E1);
    run("wren", 3'd0, 8'h00, 2'd0, 24'h0, 24'h0, 0);
    run("wrdi", 3'd1, 8'h00, 2'd0, 24'h0, 24'h0, 0);
    run("wrreg1", 3'd4, 8'h02, 2'd1, 24'h0000C7, 24'h0, 0);
    chk("wrreg1_mosi_lit", fr_bits[nfr-1], 64'h0000_7100_0000_02C7);
    chk("wrreg1_bits_lit", fr_n[nfr-1], 48);
    run("wrreg3", 3'd4, 8'hA0, 2'd3, 24'h332211, 24'h0, 0);
    run("ill_op6", 3'd6, 8'h01, 2'd1, 24'h0, 24'h0, 0);
    chk("ill_op6_latency", last_rsp_cyc - acc + 1, 1);
    run("ill_len0", 3'd3, 8'h01, 2'd0, 24'h0, 24'h0, 0);
    run("ill_op7", 3'd7, 8'h00, 2'd2, 24'h0, 24'h0, 0);
    run("ill_wr_len0", 3'd4, 8'h05, 2'd0, 24'h123456, 24'h0, 0);
    run("abort", 3'd3, 8'h01, 2'd2, 24'h0, 24'h00813C, 82);
    run("rdsr_after", 3'd2, 8'h00, 2'd0, 24'h0, 24'h000042, 0);
    chk("rdsr_after_rdata_lit", last_rdata, 24'h000042);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sc_reg_host.md
# sc_reg_host

Host-side SPI initiator for the flash status/control register set. It accepts single register requests from the system side and serialises them as SPI mode-0 transactions: WREN 06h, WRDI 04h, RDSR 05h, read-register 65h and write-register 71h. It returns read data and completion on a one-cycle response strobe. It sits between the system control logic and the flash pins, opposite the flash-side status/control register block, which commits writes on the rising edge of CS.

## Interface
- CLK_DIV, 2: SCK half-period in clk cycles; legal range 1..255.
- CS_IDLE, 4: minimum spi_cs_n high time between transactions, in clk cycles; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_op  in  3  0 WREN, 1 WRDI, 2 RDSR, 3 RDREG (65h), 4 WRREG (71h); 5..7 illegal.
- req_addr  in  8  register address; sent as 32-bit address {24'h0, req_addr}.
- req_len  in  2  data bytes for RDREG/WRREG, 1..3; 0 illegal.
- req_wdata  in  24  write bytes; byte0 is [7:0] and is sent first.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  valid with rsp_valid; illegal request.
- rsp_rdata  out  24  read bytes; byte0 is [7:0] and is received first; unused bytes are 0.
- busy  out  1  high from acceptance until return to IDLE.
- spi_sck  out  1  serial clock; idles low.
- spi_cs_n  out  1  chip select, active-low.
- spi_mosi  out  1  serial out, MSB first.
- spi_miso  in  1  serial in.

## Operation
- Reset values:
  - req_ready = 1, busy = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - spi_sck = 0, spi_cs_n = 1, spi_mosi = 0.
- A request is accepted on a clk edge where req_valid && req_ready. At acceptance, op, addr, len and wdata are captured into internal registers.
- An illegal request (op 5..7, or len 0 with op 3/4) is never transmitted:
  - rsp_valid = 1 and rsp_err = 1 on the next cycle.
  - The block returns directly to IDLE; spi_cs_n stays high.
- Frame content by op:
  - WREN/WRDI: 8 bits (opcode only).
  - RDSR: 8-bit opcode, then 8 read bits.
  - RDREG: 8-bit opcode, 32-bit address, then 8×len read bits.
  - WRREG: 8-bit opcode, 32-bit address, then 8×len write bits.
- During read phases spi_mosi = 0. Read bits shift in MSB first per byte.
- FSM states:
  - IDLE → CS_SETUP on accept of a legal request.
  - CS_SETUP (CLK_DIV cycles, cs_n low, sck low) → SHIFT.
  - SHIFT (2·CLK_DIV cycles per bit) → CS_HOLD after the last falling SCK edge.
  - CS_HOLD (CLK_DIV cycles, sck low) → CS_GAP. spi_cs_n rises on entry to CS_GAP.
  - CS_GAP (CS_IDLE cycles, cs_n high) → IDLE, or → CS_SETUP for a chained frame.
- Bit counter is 6 bits wide (maximum frame 64 bits). Frame length is computed at acceptance.
- Response timing:
  - rsp_valid pulses in the first CS_GAP cycle of the final frame.
  - rsp_rdata is updated in the same cycle and held until the next response.
- req_valid is ignored while busy. A request held across busy is accepted on the first IDLE cycle.
- Asynchronous reset mid-frame:
  - All outputs return to their reset values immediately.
  - No response is produced and the partial frame is abandoned.
  - The flash-side register commits on CS rise, so a truncated 71h write must be ignored by the flash.

## Timing
- SPI mode 0:
  - spi_mosi changes only while spi_sck is low: at CS_SETUP entry for bit 0, and at each falling edge for later bits.
  - spi_miso is sampled on the clk cycle in which spi_sck rises.
- SCK high and low phases are each exactly CLK_DIV clk cycles.
- Latency of a legal single frame of N bits, from the acceptance edge to rsp_valid: CLK_DIV + 2·CLK_DIV·N + CLK_DIV + 1 cycles.
- req_ready returns high CS_IDLE cycles after spi_cs_n rises.
- With CLK_DIV=1, spi_sck toggles every clk; no other behaviour changes.

## Configuration
- SC_REG_HOST_AUTO_WREN_EN defined: a legal WRREG is preceded automatically by an 8-bit 06h frame.
  - The 06h frame gets its own CS_SETUP, SHIFT, CS_HOLD and CS_GAP (CS_IDLE cycles).
  - The 71h frame follows without returning to IDLE.
  - Only one rsp_valid is produced, after the 71h frame.
- Not defined: WRREG sends the 71h frame only. The caller must issue WREN first; the flash's write-enable latch is not checked.

## Test plan
- Reset: rst_n low → spi_cs_n=1, spi_sck=0, spi_mosi=0, req_ready=1, rsp_valid=0.
- RDSR, CLK_DIV=2, spi_miso returns 8'hA5 → MOSI shows 05h; 16 SCK rising edges; rsp_valid at acceptance+69 cycles; rsp_rdata=24'h0000A5, rsp_err=0.
- RDREG addr=01h, len=2, flash returns 3Ch then 81h → MOSI shows 65h 00 00 00 01; rsp_rdata=24'h00813C.
- WRREG addr=02h, len=1, wdata=24'h0000C7 → MOSI shows 71h 00 00 00 02 C7 (48 bits).
  - With SC_REG_HOST_AUTO_WREN_EN: a separate 06h frame precedes it, separated by ≥CS_IDLE cycles of cs_n high.
  - Without the macro: no 06h frame is sent.
- Illegal requests op=6, and op=3 with len=0 → rsp_valid and rsp_err=1 one cycle after acceptance; spi_cs_n never falls.
- rst_n asserted mid-address of a RDREG → spi_cs_n=1 immediately; no rsp_valid; the next RDSR completes normally.
